// File: rtl/polyphase_addr_gen.sv
// Address sequencer for a polyphase interpolation FIR: writes samples into a
// circular data RAM and walks PHASES x TAPS data/coefficient pairs per sample.
module polyphase_addr_gen #(
    parameter  int TAPS    = 25,
    parameter  int PHASES  = 4,
    parameter  int DATA_AW = 8,
    parameter  int COEF_AW = 8,
    localparam int PHASE_W = (PHASES > 1) ? $clog2(PHASES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic               wr_en_o,
    output logic [DATA_AW-1:0] wr_addr_o,
    output logic [DATA_AW-1:0] addr_data_o,
    output logic [COEF_AW-1:0] addr_factor_o,
    output logic               addr_valid_o,
    output logic               mac_first_o,
    output logic               mac_last_o,
    output logic [PHASE_W-1:0] phase_o,
    output logic               overrun_o
);

    localparam int TAP_W = $clog2(TAPS);
    localparam logic [TAP_W-1:0]   TAP_LAST   = TAP_W'(TAPS - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [DATA_AW-1:0] wr_ptr_q;
    logic [DATA_AW-1:0] newest_q;
    logic [TAP_W-1:0]   tap_q;
    logic [DATA_AW-1:0] addr_data_q;
    logic [COEF_AW-1:0] addr_factor_q;
    logic               addr_valid_q;
    logic               mac_first_q;
    logic               mac_last_q;
    logic [PHASE_W-1:0] phase_q;
    logic               overrun_q;

    logic last_beat;
    logic in_ready;
    logic transfer;

    // The final pair of a burst frees the sequencer so the next sample can
    // start with no bubble in addr_valid.
    assign last_beat = (state_q == RUN) && (tap_q == TAP_LAST) && (phase_q == PHASE_LAST);
    assign in_ready  = rst_n && en_i && ((state_q == IDLE) || last_beat);
    assign transfer  = in_valid_i && in_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            newest_q      <= '0;
            tap_q         <= '0;
            addr_data_q   <= '0;
            addr_factor_q <= '0;
            addr_valid_q  <= 1'b0;
            mac_first_q   <= 1'b0;
            mac_last_q    <= 1'b0;
            phase_q       <= '0;
            overrun_q     <= 1'b0;
        end else if (en_i) begin
            // With rst_n and en_i both high, !in_ready means mid-burst.
            if (in_valid_i && !in_ready) begin
                overrun_q <= 1'b1;
            end

            if (transfer) begin
                state_q       <= RUN;
                newest_q      <= wr_ptr_q;
                wr_ptr_q      <= wr_ptr_q + 1'b1;
                tap_q         <= '0;
                phase_q       <= '0;
                addr_factor_q <= '0;
                addr_data_q   <= wr_ptr_q;
                addr_valid_q  <= 1'b1;
                mac_first_q   <= 1'b1;
                mac_last_q    <= 1'b0;
            end else if (state_q == RUN) begin
                if (last_beat) begin
                    // Addresses and phase hold; only the qualifiers drop.
                    state_q      <= IDLE;
                    addr_valid_q <= 1'b0;
                    mac_first_q  <= 1'b0;
                    mac_last_q   <= 1'b0;
                end else begin
                    addr_factor_q <= addr_factor_q + 1'b1;
                    if (tap_q == TAP_LAST) begin
                        tap_q       <= '0;
                        phase_q     <= phase_q + 1'b1;
                        addr_data_q <= newest_q;
                        mac_first_q <= 1'b1;
                        mac_last_q  <= 1'b0;
                    end else begin
                        tap_q       <= tap_q + 1'b1;
                        addr_data_q <= addr_data_q - 1'b1;
                        mac_first_q <= 1'b0;
                        mac_last_q  <= (tap_q == TAP_LAST - 1'b1);
                    end
                end
            end
        end
    end

    assign in_ready_o    = in_ready;
    assign wr_en_o       = transfer;
    assign wr_addr_o     = wr_ptr_q;
    assign addr_data_o   = addr_data_q;
    assign addr_factor_o = addr_factor_q;
    assign addr_valid_o  = addr_valid_q;
    assign mac_first_o   = mac_first_q;
    assign mac_last_o    = mac_last_q;
    assign phase_o       = phase_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_polyphase_addr_gen.sv
// Bench for polyphase_addr_gen: directed vector table, corner-case sequences
// and random traffic checked against a burst-index reference model.
module tb_polyphase_addr_gen;

    localparam int TAPS    = 25;
    localparam int PHASES  = 4;
    localparam int DATA_AW = 8;
    localparam int COEF_AW = 8;
    localparam int PT      = PHASES * TAPS;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               wr_en;
    logic [DATA_AW-1:0] wr_addr;
    logic [DATA_AW-1:0] addr_data;
    logic [COEF_AW-1:0] addr_factor;
    logic               addr_valid;
    logic               mac_first;
    logic               mac_last;
    logic [1:0]         phase;
    logic               overrun;

    polyphase_addr_gen #(
        .TAPS(TAPS), .PHASES(PHASES), .DATA_AW(DATA_AW), .COEF_AW(COEF_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .wr_en_o(wr_en), .wr_addr_o(wr_addr),
        .addr_data_o(addr_data), .addr_factor_o(addr_factor),
        .addr_valid_o(addr_valid), .mac_first_o(mac_first),
        .mac_last_o(mac_last), .phase_o(phase), .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a burst is just an index k = 0..PT-1 after the accept.
    int                 m_k = -1;
    logic [DATA_AW-1:0] m_wr_ptr = '0;
    logic [DATA_AW-1:0] m_newest = '0;
    logic               m_ovr = 1'b0;
    logic               m_valid = 1'b0, m_first = 1'b0, m_last = 1'b0;
    logic [COEF_AW-1:0] m_factor = '0;
    logic [DATA_AW-1:0] m_data = '0;
    logic [1:0]         m_phase = '0;
    int                 n_acc = 0;
    int                 n_valid = 0;

    task automatic model_update(input logic r, input logic e, input logic v, input logic rdy);
        if (!r) begin
            m_k = -1; m_wr_ptr = '0; m_newest = '0; m_ovr = 1'b0;
            m_valid = 1'b0; m_first = 1'b0; m_last = 1'b0;
            m_factor = '0; m_data = '0; m_phase = '0;
        end else if (e) begin
            if (v && !rdy) m_ovr = 1'b1;
            if (v && rdy) begin
                m_newest = m_wr_ptr;
                m_wr_ptr = m_wr_ptr + 1'b1;
                m_k = 0;
            end else if (m_k >= 0 && m_k < PT - 1) begin
                m_k++;
            end else begin
                m_k = -1;
            end
            if (m_k >= 0) begin
                m_valid  = 1'b1;
                m_factor = COEF_AW'(m_k);
                m_data   = m_newest - DATA_AW'(m_k % TAPS);
                m_phase  = 2'(m_k / TAPS);
                m_first  = (m_k % TAPS == 0);
                m_last   = (m_k % TAPS == TAPS - 1);
            end else begin
                m_valid = 1'b0; m_first = 1'b0; m_last = 1'b0;
            end
        end
    endtask

    // One clock: drive, check combinational outputs mid-cycle, clock, check registers.
    task automatic tick(input logic r, input logic e, input logic v);
        logic rdy;
        rst_n = r; en = e; in_valid = v;
        #4;
        rdy = r && e && (m_k < 0 || m_k == PT - 1);
        check("in_ready", in_ready, rdy);
        check("wr_en", wr_en, v && rdy);
        if (r) check("wr_addr", wr_addr, m_wr_ptr);
        if (wr_en === 1'b1) n_acc++;
        @(posedge clk);
        model_update(r, e, v, rdy);
        #1;
        check("addr_valid", addr_valid, m_valid);
        check("addr_factor", addr_factor, m_factor);
        check("addr_data", addr_data, m_data);
        check("mac_first", mac_first, m_first);
        check("mac_last", mac_last, m_last);
        check("phase", phase, m_phase);
        check("overrun", overrun, m_ovr);
        if (e && addr_valid === 1'b1) n_valid++;
    endtask

    task automatic start_burst();
        tick(1'b0, 1'b1, 1'b0);
        n_acc = 0; n_valid = 0;
        tick(1'b1, 1'b1, 1'b1);
    endtask

    task automatic run_to(input int k);
        for (int i = 0; i < 2 * PT && m_k != k; i++) tick(1'b1, 1'b1, 1'b0);
        check("run_to_reached", 32'(m_k), 32'(k));
    endtask

    typedef struct {
        logic       r, e, v;
        logic       x_ready, x_wr_en;
        logic [7:0] x_wr_addr;
        logic       x_valid;
        logic [7:0] x_factor, x_data;
        logic       x_first, x_last;
        logic [1:0] x_phase;
        logic       x_ovr;
    } vec_t;

    vec_t vecs[10];

    initial begin
        //          r  e  v  rdy wr  wa   val fac  dat    fst lst ph ovr
        vecs[0] = '{0, 1, 0, 0,  0,  0,   0,  0,   0,     0,  0,  0, 0};
        vecs[1] = '{1, 1, 1, 1,  1,  0,   1,  0,   0,     1,  0,  0, 0};
        vecs[2] = '{1, 1, 0, 0,  0,  0,   1,  1,   8'hff, 0,  0,  0, 0};
        vecs[3] = '{1, 0, 1, 0,  0,  0,   1,  1,   8'hff, 0,  0,  0, 0};
        vecs[4] = '{1, 1, 0, 0,  0,  0,   1,  2,   8'hfe, 0,  0,  0, 0};
        vecs[5] = '{0, 1, 0, 0,  0,  0,   0,  0,   0,     0,  0,  0, 0};
        vecs[6] = '{1, 1, 0, 1,  0,  0,   0,  0,   0,     0,  0,  0, 0};
        vecs[7] = '{1, 1, 1, 1,  1,  0,   1,  0,   0,     1,  0,  0, 0};
        vecs[8] = '{1, 1, 1, 0,  0,  0,   1,  1,   8'hff, 0,  0,  0, 1};
        vecs[9] = '{1, 0, 0, 0,  0,  0,   1,  1,   8'hff, 0,  0,  0, 1};

        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            rst_n = vecs[i].r; en = vecs[i].e; in_valid = vecs[i].v;
            #4;
            check("tbl_in_ready", in_ready, vecs[i].x_ready);
            check("tbl_wr_en", wr_en, vecs[i].x_wr_en);
            if (vecs[i].x_wr_en) check("tbl_wr_addr", wr_addr, vecs[i].x_wr_addr);
            @(posedge clk);
            #1;
            check("tbl_addr_valid", addr_valid, vecs[i].x_valid);
            check("tbl_addr_factor", addr_factor, vecs[i].x_factor);
            check("tbl_addr_data", addr_data, vecs[i].x_data);
            check("tbl_mac_first", mac_first, vecs[i].x_first);
            check("tbl_mac_last", mac_last, vecs[i].x_last);
            check("tbl_phase", phase, vecs[i].x_phase);
            check("tbl_overrun", overrun, vecs[i].x_ovr);
        end

        // Single sample: exactly PT valid cycles, then idle.
        start_burst();
        for (int i = 0; i < PT + 5; i++) tick(1'b1, 1'b1, 1'b0);
        check("single_burst_len", 32'(n_valid), 32'(PT));
        check("single_idle_after", addr_valid, 1'b0);

        // in_valid held high: accepts every PT cycles, overrun set.
        start_burst();
        for (int i = 0; i < 2 * PT; i++) tick(1'b1, 1'b1, 1'b1);
        check("b2b_accepts", 32'(n_acc), 32'd3);
        check("b2b_continuous", 32'(n_valid), 32'(2 * PT + 1));
        check("b2b_overrun", overrun, 1'b1);

        // in_valid only offered when ready: no overrun.
        start_burst();
        for (int i = 0; i < 3 * PT; i++) tick(1'b1, 1'b1, (m_k < 0 || m_k == PT - 1));
        check("polite_overrun", overrun, 1'b0);

        // Stall at factor 40 for three cycles.
        start_burst();
        run_to(40);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
        check("stall_hold", addr_factor, 8'd40);
        for (int i = 0; i < PT; i++) tick(1'b1, 1'b1, 1'b0);
        check("stall_burst_len", 32'(n_valid), 32'(PT));

        // Overrun pulse mid-burst.
        start_burst();
        run_to(10);
        tick(1'b1, 1'b1, 1'b1);
        check("ovr_set", overrun, 1'b1);
        check("ovr_no_accept", 32'(n_acc), 32'd1);
        for (int i = 0; i < PT; i++) tick(1'b1, 1'b1, 1'b0);
        check("ovr_sticky", overrun, 1'b1);

        // Reset mid-burst at factor 60.
        start_burst();
        run_to(60);
        tick(1'b0, 1'b1, 1'b0);
        check("rst_mid_valid", addr_valid, 1'b0);
        check("rst_mid_factor", addr_factor, 8'd0);
        tick(1'b1, 1'b1, 1'b1);
        check("rst_mid_restart", addr_data, 8'd0);

        // Write-pointer wrap: 255 accepts, then two more at 255 and 0.
        start_burst();
        for (int i = 0; i < 260 * PT && n_acc < 257; i++) tick(1'b1, 1'b1, 1'b1);
        check("wrap_accepts", 32'(n_acc), 32'd257);
        check("wrap_ptr", wr_addr, 8'd1);
        check("wrap_newest_data", addr_data, 8'd0);
        for (int i = 0; i < PT; i++) tick(1'b1, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 499) != 0), ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
